// File: rtl/tile_scheduler.sv
`timescale 1ns/1ps
// tile_scheduler: per-frame sequencer for the falling-tile lanes. At entry
// to vertical blank it steps every lane's top_y by `speed` (wrapping at the
// screen height), streams each descriptor over valid/ready, then pulses
// `animate` so the square generators latch the new geometry.
module tile_scheduler #(
   parameter int LANES    = 4,
   parameter int SCREEN_H = 480,
   parameter int LANE_W   = 160
) (
   input  logic        clk,
   input  logic        res,
   input  logic [9:0]  x,
   input  logic [8:0]  y,
   input  logic        run,
   input  logic [3:0]  speed,
   input  logic        cfg_we,
   input  logic [2:0]  cfg_lane,
   input  logic [31:0] cfg_data,
   output logic        desc_valid,
   input  logic        desc_ready,
   output logic [2:0]  desc_lane,
   output logic [31:0] desc_data,
   output logic        animate,
   output logic        busy,
   output logic [15:0] wrap_cnt,
   output logic [7:0]  overrun_cnt
);

   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {IDLE, UPDATE, SEND, DONE} state_t;

   state_t        state, state_nx;
   logic [IW-1:0] lane_i, lane_nx;

   // Lane descriptor storage
   logic [9:0] top_y  [LANES];
   logic [9:0] len    [LANES];
   logic       lfoot  [LANES];
   logic       rfoot  [LANES];

   // Vertical-blank trigger history
   logic match_now, match_q, match_d, trig;

   // Update datapath
   logic [10:0]   sum;
   logic          wrap;
   logic [9:0]    new_y;
   logic [9:0]    top_x;
   logic          cfg_hit;
   logic [IW-1:0] cfg_idx;
   logic          upd_blocked;
   logic          cfg_unused;

   assign match_now   = (y == 9'(SCREEN_H)) && (x == 10'd0);
   assign cfg_hit     = cfg_we && (int'(cfg_lane) < LANES);
   assign cfg_idx     = cfg_lane[IW-1:0];
   assign upd_blocked = cfg_hit && (cfg_idx == lane_i);
   assign sum         = {1'b0, top_y[lane_i]} + {7'd0, speed};
   assign wrap        = (sum >= 11'(SCREEN_H));
   assign new_y       = wrap ? 10'(sum - 11'(SCREEN_H)) : sum[9:0];
   assign top_x       = 10'(int'(lane_i) * LANE_W);
   assign cfg_unused  = ^cfg_data[29:20];

   // Register the match, then turn its rising edge into a one-cycle trigger
   always_ff @(posedge clk) begin
      // NOTE: every clocked assignment is non-blocking so all registers
      // sample pre-edge values regardless of statement order.
      if (res) begin
         match_q <= 1'b0;
         match_d <= 1'b0;
         trig    <= 1'b0;
      end else begin
         match_q <= match_now;
         match_d <= match_q;
         trig    <= match_q & ~match_d;
      end
   end

   // FSM state and lane pointer
   always_ff @(posedge clk) begin
      if (res) begin
         state  <= IDLE;
         lane_i <= '0;
      end else begin
         state  <= state_nx;
         lane_i <= lane_nx;
      end
   end

   // Next-state decode and handshake outputs
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves one
      // unassigned and no latch is inferred.
      state_nx   = state;
      lane_nx    = lane_i;
      desc_valid = 1'b0;
      desc_lane  = 3'd0;
      desc_data  = 32'd0;
      animate    = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (trig && run) begin
               state_nx = UPDATE;
               lane_nx  = '0;
            end
         end
         UPDATE: state_nx = SEND;
         SEND: begin
            desc_valid = 1'b1;
            desc_lane  = 3'(lane_i);
            desc_data  = {rfoot[lane_i], lfoot[lane_i], len[lane_i],
                          top_y[lane_i], top_x};
            if (desc_ready) begin
               if (lane_i == IW'(LANES - 1)) begin
                  state_nx = DONE;
               end else begin
                  state_nx = UPDATE;
                  lane_nx  = IW'(lane_i + 1'b1);
               end
            end
         end
         DONE: begin
            animate  = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Lane registers: CPU writes take priority over the frame update
   always_ff @(posedge clk) begin
      if (res) begin
         // NOTE: the lane array is reset explicitly because the first frame
         // after reset must advance from all-zero descriptors.
         for (int k = 0; k < LANES; k++) begin
            top_y[k] <= '0;
            len[k]   <= '0;
            lfoot[k] <= 1'b0;
            rfoot[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < LANES; k++) begin
            if (cfg_hit && (cfg_idx == IW'(k))) begin
               top_y[k] <= cfg_data[9:0];
               len[k]   <= cfg_data[19:10];
               lfoot[k] <= cfg_data[30];
               rfoot[k] <= cfg_data[31];
            end else if ((state == UPDATE) && (lane_i == IW'(k))) begin
               top_y[k] <= new_y;
               if (wrap) begin
                  lfoot[k] <= 1'b0;
                  rfoot[k] <= 1'b0;
               end
            end
         end
      end
   end

   // Saturating event counters; a wrap overridden by a CPU write is not counted
   always_ff @(posedge clk) begin
      if (res) begin
         wrap_cnt    <= '0;
         overrun_cnt <= '0;
      end else begin
         if ((state == UPDATE) && wrap && !upd_blocked && (wrap_cnt != '1))
            wrap_cnt <= wrap_cnt + 16'd1;
         if (trig && (state != IDLE) && (overrun_cnt != '1))
            overrun_cnt <= overrun_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_tile_scheduler.sv
`timescale 1ns/1ps
// Directed bench for tile_scheduler: a table of seeded frames with
// hand-computed descriptors, plus sequences for stall, overrun, CPU
// collision and mid-sequence reset.
module tb_tile_scheduler;

   logic        clk = 1'b0;
   logic        res;
   logic [9:0]  x;
   logic [8:0]  y;
   logic        run;
   logic [3:0]  speed;
   logic        cfg_we;
   logic [2:0]  cfg_lane;
   logic [31:0] cfg_data;
   logic        desc_valid;
   logic        desc_ready;
   logic [2:0]  desc_lane;
   logic [31:0] desc_data;
   logic        animate;
   logic        busy;
   logic [15:0] wrap_cnt;
   logic [7:0]  overrun_cnt;

   tile_scheduler dut (
      .clk(clk), .res(res), .x(x), .y(y), .run(run), .speed(speed),
      .cfg_we(cfg_we), .cfg_lane(cfg_lane), .cfg_data(cfg_data),
      .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_lane(desc_lane), .desc_data(desc_data),
      .animate(animate), .busy(busy),
      .wrap_cnt(wrap_cnt), .overrun_cnt(overrun_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]       speed;
      logic [3:0][31:0] seed;
      logic [3:0][31:0] exp;
      int               wraps;
   } vec_t;

   vec_t vecs [4];

   int checks   = 0;
   int failures = 0;

   // Frame capture results
   logic [31:0] cap_data [8];
   logic [2:0]  cap_lane [8];
   int n_acc, busy_cycles, anim_count, anim_at, stall_bad;
   bit frame_done;

   int exp_wrap    = 0;
   int exp_overrun = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] sp,
                               input logic [31:0] s0, s1, s2, s3,
                               input logic [31:0] e0, e1, e2, e3,
                               input int w);
      vec_t v;
      v.speed = sp;
      v.seed[0] = s0; v.seed[1] = s1; v.seed[2] = s2; v.seed[3] = s3;
      v.exp[0]  = e0; v.exp[1]  = e1; v.exp[2]  = e2; v.exp[3]  = e3;
      v.wraps = w;
      return v;
   endfunction

   task automatic cfg_write(input logic [2:0] lane, input logic [31:0] data);
      @(negedge clk);
      cfg_we = 1'b1; cfg_lane = lane; cfg_data = data;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic seed_lanes(input logic [3:0][31:0] s);
      for (int k = 0; k < 4; k++) cfg_write(3'(k), s[k]);
      // Out-of-range lane index must not disturb any lane
      cfg_write(3'd4, 32'hFFFF_FFFF);
   endtask

   // One frame: pulse the vblank match, then step until animate has passed.
   // Optionally stall one lane, or inject a CPU write to lane 0 plus a
   // second match in the first busy cycle (UPDATE(0)).
   task automatic run_frame(input int stall_lane, input int stall_n,
                            input bit inject, input logic [31:0] inj_data);
      int stall_left;
      bit holding, injected, seen_anim;
      logic [31:0] hold_d;
      logic [2:0]  hold_l;
      n_acc = 0; busy_cycles = 0; anim_count = 0; anim_at = 0; stall_bad = 0;
      frame_done = 1'b0; stall_left = stall_n; holding = 1'b0;
      injected = 1'b0; seen_anim = 1'b0; hold_d = '0; hold_l = '0;
      @(negedge clk); y = 9'd480; x = 10'd0;
      @(negedge clk); y = 9'd0;   x = 10'd1;
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         cfg_we = 1'b0; y = 9'd0; x = 10'd1; desc_ready = 1'b1;
         if (busy) busy_cycles++;
         if (animate) begin
            anim_count++;
            anim_at = busy_cycles;
            seen_anim = 1'b1;
         end
         if (inject && busy && !injected) begin
            cfg_we = 1'b1; cfg_lane = 3'd0; cfg_data = inj_data;
            y = 9'd480; x = 10'd0;
            injected = 1'b1;
         end
         if (stall_n > 0 && desc_valid && desc_lane == 3'(stall_lane)) begin
            if (!holding) begin
               hold_d = desc_data; hold_l = desc_lane; holding = 1'b1;
            end else if (desc_data !== hold_d || desc_lane !== hold_l) begin
               stall_bad++;
            end
            if (stall_left > 0) begin
               desc_ready = 1'b0;
               stall_left--;
            end
         end
         if (desc_valid && desc_ready && n_acc < 8) begin
            cap_data[n_acc] = desc_data;
            cap_lane[n_acc] = desc_lane;
            n_acc++;
         end
         if (seen_anim && !busy) begin
            frame_done = 1'b1;
            break;
         end
      end
      check("frame_completes", 32'(frame_done), 32'd1);
   endtask

   initial begin
      int bad;
      bit reached;

      vecs[0] = mk(4'd3,
                   32'h0001_900A, 32'hC000_C9DE, 32'h4000_78C8, 32'h8007_81DC,
                   32'h0640_3400, 32'h0320_04A0, 32'h41E3_2D40, 32'h9E07_7DE0, 1);
      vecs[1] = mk(4'd5,
                   32'h4000_1DDB, 32'hC000_C9DE, 32'hC00F_FC00, 32'h0000_0BE8,
                   32'h0070_0000, 32'h0320_0CA0, 32'hFFF0_1540, 32'h0028_35E0, 3);
      vecs[2] = mk(4'd0,
                   32'h0000_01DF, 32'h4000_01E0, 32'h0000_0000, 32'h8000_1464,
                   32'h0007_7C00, 32'h0000_00A0, 32'h0000_0140, 32'h8051_91E0, 1);
      vecs[3] = mk(4'd15,
                   32'h8000_0DD1, 32'hC000_01D0, 32'h0000_0000, 32'h0000_0000,
                   32'h0030_0000, 32'hC007_7CA0, 32'h0000_3D40, 32'h0000_3DE0, 1);

      res = 1'b1; run = 1'b1; x = 10'd1; y = 9'd0; speed = 4'd0;
      cfg_we = 1'b0; cfg_lane = 3'd0; cfg_data = 32'd0; desc_ready = 1'b1;
      repeat (3) @(negedge clk);
      res = 1'b0;

      // Reset values, then 100 quiet cycles with run=1 and no trigger
      @(negedge clk);
      check("rst_desc_valid", 32'(desc_valid), 32'd0);
      check("rst_animate",    32'(animate),    32'd0);
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_desc_lane",  32'(desc_lane),  32'd0);
      check("rst_desc_data",  desc_data,       32'd0);
      check("rst_wrap_cnt",   32'(wrap_cnt),   32'd0);
      check("rst_overrun",    32'(overrun_cnt), 32'd0);
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (desc_valid || animate || busy || desc_lane != 3'd0 ||
             desc_data != 32'd0 || wrap_cnt != 16'd0 || overrun_cnt != 8'd0) bad++;
      end
      check("quiet_100_cycles", 32'(bad), 32'd0);

      // Trigger with run=0 is ignored and not counted
      run = 1'b0;
      @(negedge clk); y = 9'd480; x = 10'd0;
      @(negedge clk); y = 9'd0;   x = 10'd1;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (busy) bad++;
      end
      check("run0_no_busy", 32'(bad), 32'd0);
      check("run0_no_overrun", 32'(overrun_cnt), 32'd0);
      run = 1'b1;

      // Table of seeded frames
      for (int v = 0; v < 4; v++) begin
         seed_lanes(vecs[v].seed);
         speed = vecs[v].speed;
         run_frame(-1, 0, 1'b0, 32'd0);
         exp_wrap += vecs[v].wraps;
         check($sformatf("v%0d_accepts", v), 32'(n_acc), 32'd4);
         for (int k = 0; k < 4; k++) begin
            check($sformatf("v%0d_desc%0d", v, k), cap_data[k], vecs[v].exp[k]);
            check($sformatf("v%0d_lane%0d", v, k), 32'(cap_lane[k]), 32'(k));
         end
         check($sformatf("v%0d_animate_count", v), 32'(anim_count), 32'd1);
         check($sformatf("v%0d_busy_to_animate", v), 32'(anim_at), 32'd9);
         check($sformatf("v%0d_wrap_cnt", v), 32'(wrap_cnt), 32'(exp_wrap));
      end

      // Back-pressure: ready low for 5 cycles in SEND(2)
      seed_lanes(vecs[0].seed);
      speed = 4'd3;
      run_frame(2, 5, 1'b0, 32'd0);
      exp_wrap += 1;
      check("stall_stable", 32'(stall_bad), 32'd0);
      check("stall_desc2", cap_data[2], 32'h41E3_2D40);
      check("stall_busy_to_animate", 32'(anim_at), 32'd14);
      check("stall_animate_count", 32'(anim_count), 32'd1);
      check("stall_wrap_cnt", 32'(wrap_cnt), 32'(exp_wrap));

      // Second trigger while busy + CPU write colliding with UPDATE(0)
      seed_lanes(vecs[0].seed);
      speed = 4'd3;
      run_frame(-1, 0, 1'b1, 32'h4000_252C);
      exp_wrap += 1;
      exp_overrun += 1;
      check("collide_lane0_cpu_wins", cap_data[0], 32'h4094_B000);
      check("collide_lane1", cap_data[1], 32'h0320_04A0);
      check("overrun_cnt", 32'(overrun_cnt), 32'(exp_overrun));
      check("collide_animate_count", 32'(anim_count), 32'd1);
      check("collide_wrap_cnt", 32'(wrap_cnt), 32'(exp_wrap));
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (busy) bad++;
      end
      check("dropped_trigger_no_rerun", 32'(bad), 32'd0);

      // Reset asserted during SEND(1)
      seed_lanes(vecs[1].seed);
      speed = 4'd1;
      @(negedge clk); y = 9'd480; x = 10'd0;
      @(negedge clk); y = 9'd0;   x = 10'd1;
      reached = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (desc_valid && desc_lane == 3'd1) begin
            reached = 1'b1;
            break;
         end
      end
      check("reach_send1", 32'(reached), 32'd1);
      desc_ready = 1'b0;
      res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      desc_ready = 1'b1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_desc_valid", 32'(desc_valid), 32'd0);
      check("midrst_animate", 32'(animate), 32'd0);
      check("midrst_wrap_cnt", 32'(wrap_cnt), 32'd0);
      check("midrst_overrun", 32'(overrun_cnt), 32'd0);
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (animate || busy) bad++;
      end
      check("midrst_no_animate", 32'(bad), 32'd0);

      // Next trigger runs a full sequence from zeroed lanes
      speed = 4'd2;
      run_frame(-1, 0, 1'b0, 32'd0);
      check("zeroed_accepts", 32'(n_acc), 32'd4);
      check("zeroed_desc0", cap_data[0], 32'h0000_0800);
      check("zeroed_desc1", cap_data[1], 32'h0000_08A0);
      check("zeroed_desc2", cap_data[2], 32'h0000_0940);
      check("zeroed_desc3", cap_data[3], 32'h0000_09E0);
      check("zeroed_animate_count", 32'(anim_count), 32'd1);
      check("zeroed_busy_to_animate", 32'(anim_at), 32'd9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tile_scheduler.md
# tile_scheduler

Per-frame sequencer for the falling-tile datapath. It holds the lane tile descriptors (position, length, foot flags) and advances every lane's vertical position once per frame, at entry to vertical blank. It streams each updated descriptor to the square-drawing registers over a valid/ready handshake, then issues the single-cycle `animate` strobe that latches the new geometry. The CPU seeds and overrides lanes through a simple write port; the block sits between the APB register file and the per-lane square generators.

## Interface
- `LANES`, 4, number of tile lanes (2..8).
- `SCREEN_H`, 480, visible lines; also the vertical wrap modulus.
- `LANE_W`, 160, lane pitch in pixels; lane i has `top_x = i*LANE_W`.
- `clk`  in  1  system clock; the single clock for the block.
- `res`  in  1  reset, synchronous and active-high.
- `x`  in  10  current pixel column.
- `y`  in  9  current pixel row.
- `run`  in  1  1 = frame updates enabled.
- `speed`  in  4  lines added to every lane's `top_y` per frame.
- `cfg_we`  in  1  CPU lane write strobe.
- `cfg_lane`  in  3  lane index for `cfg_we`; indices `>= LANES` are ignored.
- `cfg_data`  in  32  seed word: [9:0] `top_y`, [19:10] `length`, [30] `left_foot`, [31] `right_foot`.
- `desc_valid`  out  1  descriptor on `desc_data` is valid.
- `desc_ready`  in  1  consumer accepts the descriptor.
- `desc_lane`  out  3  lane index of the current descriptor.
- `desc_data`  out  32  {`right_foot`, `left_foot`, `length`[9:0], `top_y`[9:0], `top_x`[9:0]}.
- `animate`  out  1  one-cycle pulse after the last lane is accepted.
- `busy`  out  1  FSM not in IDLE.
- `wrap_cnt`  out  16  total lane wrap events, saturating.
- `overrun_cnt`  out  8  triggers dropped while busy, saturating.

## Operation
- Trigger: the registered match `(y == SCREEN_H) && (x == 0)`. A trigger pulse occurs only on the rising edge of the match, so there is at most one pulse per frame.
- FSM states: IDLE, UPDATE, SEND, DONE. The lane pointer `i` is 0 on entry to UPDATE from IDLE.
- IDLE -> UPDATE(0) on a trigger with `run` = 1. A trigger with `run` = 0 is ignored and counted nowhere.
- UPDATE(i): `sum = top_y[i] + speed`, computed 11-bit unsigned.
  - If `sum >= SCREEN_H`: `top_y[i] = sum - SCREEN_H` (truncated to 10 bits), both foot flags of lane i are cleared, and `wrap_cnt` increments.
  - Otherwise `top_y[i] = sum`.
  - UPDATE always goes to SEND(i) on the next edge.
- SEND(i): `desc_valid` = 1. `desc_data` and `desc_lane` are stable until the transfer completes.
  - On `desc_valid && desc_ready`: go to UPDATE(i+1), or to DONE if `i == LANES-1`.
- DONE: `animate` = 1 for exactly one cycle, then IDLE.
- A trigger arriving in any state other than IDLE is dropped and `overrun_cnt` increments.
- CPU writes (`cfg_we`) are accepted in every state and load all fields of lane `cfg_lane` on the next edge.
  - If a write hits the lane being updated in the same cycle, the write wins and the update result is discarded.
  - If a write hits lane i during SEND(i), `desc_data` changes to the new value; the consumer receives whatever is present at acceptance.
- `length` and the foot flags are never modified by the FSM except for the foot-clear on wrap.

## Timing
- Reset values:
  - Outputs: `desc_valid` = 0, `animate` = 0, `busy` = 0, `desc_lane` = 0, `desc_data` = 0, both counters 0.
  - Internal: all lane registers 0, FSM in IDLE, trigger history cleared.
- Reset is synchronous. Asserted mid-sequence, it returns the FSM to IDLE on that edge with no `animate` pulse and drops any pending descriptor.
- Trigger registration adds 1 cycle: with the match at edge E, the FSM is in UPDATE(0) after edge E+2.
- Per lane: 1 UPDATE cycle plus at least 1 SEND cycle. With `desc_ready` tied high, `animate` asserts 2*`LANES` + 1 cycles after the FSM leaves IDLE, which is 9 cycles for `LANES` = 4.
- `busy` = 1 from UPDATE(0) through DONE inclusive.
- Counters saturate at all-ones and never wrap.

## Test plan
- Reset with `run` = 1 and no trigger -> all outputs 0 for 100 cycles; no `animate`.
- Lane 0 seeded with `top_y` = 10, `length` = 100, `speed` = 3, `desc_ready` = 1, one trigger -> lane 0 descriptor is `0x06403400`; `animate` pulses once, 9 cycles after `busy` rises.
- Lane 1 seeded with `top_y` = 478, feet = 11, `speed` = 5 -> lane 1 `top_y` = 3, `top_x` = 160, feet = 00, `wrap_cnt` = 1.
- `desc_ready` held low for 5 cycles during SEND(2) -> `desc_valid`, `desc_data` and `desc_lane` stay constant; `animate` is delayed by 5 cycles.
- Second trigger while `busy`, and a `cfg_we` to lane 0 in the same cycle as UPDATE(0) -> `overrun_cnt` = 1; lane 0 holds the CPU value.
- `res` asserted during SEND(1) -> next cycle is IDLE, `desc_valid` = 0, no `animate`; the next trigger runs a full 4-lane sequence from zeroed lanes.
